// File: rtl/alu_if.sv
// Operand/select/result bundle between the execute-stage operand muxes and the ALU.
// The master drives operands and select; the slave (ALU) returns the registered result.
interface alu_if;
  logic [31:0] Data_A;
  logic [31:0] Data_B;
  logic [3:0]  ALUSel;
  logic [31:0] ALU_out;

  modport master (
    output Data_A,
    output Data_B,
    output ALUSel,
    input  ALU_out
  );

  modport slave (
    input  Data_A,
    input  Data_B,
    input  ALUSel,
    output ALU_out
  );
endinterface

// File: rtl/alu.sv
// RV32I integer ALU with one registered output stage (single-cycle latency).
// Optional macro ALU_PASS_B_EN enables ALUSel 1111 as a Data_B pass-through (LUI).
module alu (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b1000;
  localparam logic [3:0] SEL_SLL  = 4'b0001;
  localparam logic [3:0] SEL_SLT  = 4'b0010;
  localparam logic [3:0] SEL_SLTU = 4'b0011;
  localparam logic [3:0] SEL_XOR  = 4'b0100;
  localparam logic [3:0] SEL_SRL  = 4'b0101;
  localparam logic [3:0] SEL_SRA  = 4'b1101;
  localparam logic [3:0] SEL_OR   = 4'b0110;
  localparam logic [3:0] SEL_AND  = 4'b0111;
`ifdef ALU_PASS_B_EN
  localparam logic [3:0] SEL_PASSB = 4'b1111;
`endif

  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        lt_signed;
  logic        lt_unsigned;
  logic [31:0] result_d;
  logic [31:0] result_q;

  assign a           = bus.Data_A;
  assign b           = bus.Data_B;
  // Shifts only ever look at the low five bits; B = 32 therefore shifts by zero.
  assign shamt       = b[4:0];
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  always_comb begin
    result_d = 32'h0000_0000;
    case (bus.ALUSel)
      SEL_ADD:   result_d = a + b;
      SEL_SUB:   result_d = a - b;
      SEL_SLL:   result_d = a << shamt;
      SEL_SLT:   result_d = {31'd0, lt_signed};
      SEL_SLTU:  result_d = {31'd0, lt_unsigned};
      SEL_XOR:   result_d = a ^ b;
      SEL_SRL:   result_d = a >> shamt;
      SEL_SRA:   result_d = $unsigned($signed(a) >>> shamt);
      SEL_OR:    result_d = a | b;
      SEL_AND:   result_d = a & b;
`ifdef ALU_PASS_B_EN
      SEL_PASSB: result_d = b;
`endif
      default:   result_d = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 32'h0000_0000;
    end else begin
      result_q <= result_d;
    end
  end

  assign bus.ALU_out = result_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered RV32I ALU.
module tb_alu;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  alu_if bus ();

  alu u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] OP_A = 32'hF000_2323;
  localparam logic [31:0] OP_B = 32'h1234_5678;

  // Inputs change on the falling edge, well away from the sampling edge.
  task automatic drive(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.ALUSel = sel;
    bus.Data_A = a;
    bus.Data_B = b;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.ALUSel = 4'b0000;
    bus.Data_A = OP_A;
    bus.Data_B = OP_B;
    #1;
    tests_run++;
    if (bus.ALU_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_initial: got %h expected %h", bus.ALU_out, 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.ALU_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_held_over_edges: got %h expected %h", bus.ALU_out, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.ALU_out !== 32'h0234_799B) begin
      tests_failed++;
      $display("FAIL reset_release_first_load: got %h expected %h", bus.ALU_out, 32'h0234_799B);
    end
    $display("[TB] reset: out=%h", bus.ALU_out);
  endtask

  task automatic test_ops();
    logic [3:0]  sels [10];
    logic [31:0] exps [10];
    sels = '{4'b0000, 4'b1000, 4'b0100, 4'b0110, 4'b0111,
             4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011};
    exps = '{32'h0234_799B, 32'hDDCB_CCAB, 32'hE234_755B, 32'hF234_777B, 32'h1000_0220,
             32'h2300_0000, 32'h0000_00F0, 32'hFFFF_FFF0, 32'h0000_0001, 32'h0000_0000};
    for (int i = 0; i < 10; i++) begin
      drive(sels[i], OP_A, OP_B);
      repeat (2) begin
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.ALU_out !== exps[i]) begin
          tests_failed++;
          $display("FAIL op_sel_%b: got %h expected %h", sels[i], bus.ALU_out, exps[i]);
        end
      end
      $display("[TB] op sel=%b out=%h", sels[i], bus.ALU_out);
    end
  endtask

  task automatic test_boundaries();
    logic [3:0]  sels [6];
    logic [31:0] as   [6];
    logic [31:0] bs   [6];
    logic [31:0] exps [6];
    sels = '{4'b0001, 4'b0010, 4'b0011, 4'b1101, 4'b0101, 4'b1101};
    as   = '{32'h0000_0001, OP_A, OP_A, 32'h8000_0000, 32'h8000_0000, 32'h7000_0000};
    bs   = '{32'h0000_0020, OP_A, OP_A, 32'hFFFF_FFE4, 32'h0000_0004, 32'h0000_0004};
    exps = '{32'h0000_0001, 32'h0, 32'h0, 32'hF800_0000, 32'h0800_0000, 32'h0700_0000};
    for (int i = 0; i < 6; i++) begin
      drive(sels[i], as[i], bs[i]);
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.ALU_out !== exps[i]) begin
        tests_failed++;
        $display("FAIL boundary_%0d_sel_%b: got %h expected %h", i, sels[i], bus.ALU_out, exps[i]);
      end
      $display("[TB] boundary %0d sel=%b out=%h", i, sels[i], bus.ALU_out);
    end
  endtask

  task automatic test_codes();
    logic [31:0] exp_passb;
`ifdef ALU_PASS_B_EN
    exp_passb = OP_B;
`else
    exp_passb = 32'h0;
`endif
    drive(4'b1111, OP_A, OP_B);
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.ALU_out !== exp_passb) begin
      tests_failed++;
      $display("FAIL code_1111: got %h expected %h", bus.ALU_out, exp_passb);
    end
    $display("[TB] code 1111 out=%h", bus.ALU_out);
    for (int c = 9; c < 16; c++) begin
      if (c == 13 || c == 15) continue;
      drive(4'(c), OP_A, OP_B);
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.ALU_out !== 32'h0) begin
        tests_failed++;
        $display("FAIL illegal_code_%0d: got %h expected %h", c, bus.ALU_out, 32'h0);
      end
      $display("[TB] illegal code %0d out=%h", c, bus.ALU_out);
    end
  endtask

  // Changing inputs every cycle: each result appears one edge later and holds until the next.
  task automatic test_back_to_back();
    drive(4'b0000, OP_A, OP_B);
    drive(4'b1000, OP_A, OP_B);
    #0;
    tests_run++;
    if (bus.ALU_out !== 32'h0234_799B) begin
      tests_failed++;
      $display("FAIL b2b_add_held: got %h expected %h", bus.ALU_out, 32'h0234_799B);
    end
    // Mid-cycle glitch on the select must not matter; only the value at the edge counts.
    #2 bus.ALUSel = 4'b0111;
    #1 bus.ALUSel = 4'b1000;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.ALU_out !== 32'hDDCB_CCAB) begin
      tests_failed++;
      $display("FAIL b2b_sub: got %h expected %h", bus.ALU_out, 32'hDDCB_CCAB);
    end
    $display("[TB] back-to-back out=%h", bus.ALU_out);
  endtask

  task automatic test_async_reset();
    drive(4'b0000, OP_A, OP_B);
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.ALU_out !== 32'h0234_799B) begin
      tests_failed++;
      $display("FAIL areset_preload: got %h expected %h", bus.ALU_out, 32'h0234_799B);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.ALU_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL areset_immediate: got %h expected %h", bus.ALU_out, 32'h0);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.ALU_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL areset_held: got %h expected %h", bus.ALU_out, 32'h0);
    end
    @(negedge clk);
    bus.ALUSel = 4'b0110;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.ALU_out !== 32'hF234_777B) begin
      tests_failed++;
      $display("FAIL areset_release_load: got %h expected %h", bus.ALU_out, 32'hF234_777B);
    end
    $display("[TB] async reset out=%h", bus.ALU_out);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_ops();
    test_boundaries();
    test_codes();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
